branch_queue: RTL
=================

// Module: branch_queue
// PURPOSE
//  Slave end of bq_push_if: allocates a BQ slot per control-flow op pushed by decode and returns its bqid.
//  Holds predicted outcome (bp_t), pc and inst id until the branch unit resolves the op.
//  On a mispredict, flushes younger entries and drives squash_if (master) with id and redirect pc.
//  Frees the head entry on commit. Sits between decode, the branch unit and the commit stage.
// PARAMETERS
//  NB_BQ_ENTRY  8  queue depth; power of two, >= 2; bqid_t = $clog2(NB_BQ_ENTRY) bits
// PORTS
//  clk            in   1       clock
//  rstn           in   1       asynchronous active-low reset
//  bq_push_io     slave  bq_push_if: valid, pc(pc_t), id(id_t), bp(bp_t) in; bqid(bqid_t) out
//  bq_full_o      out  1       no free entry this cycle
//  bq_overflow_o  out  1       sticky: a push arrived while full (error, verification hook)
//  bu_valid_i     in   1       branch unit resolves an entry
//  bu_bqid_i      in   bqid_t  entry being resolved
//  bu_taken_i     in   1       actual direction
//  bu_target_i    in   pc_t    actual target (meaningful when taken)
//  cm_valid_i     in   1       commit retires the oldest branch
//  head_resolved_o out 1       head entry valid and resolved (commit may pop)
//  squash_io      master squash_if: valid, id(id_t) = mispredicting op, pc(pc_t) = redirect
// BEHAVIOUR
//  - Reset (async on !rstn): head=tail=0 (with wrap bit), all entry valid=0; squash_io.valid=0,
//    squash_io.id=0, squash_io.pc=0, bq_overflow_o=0; bq_full_o=0, head_resolved_o=0.
//  - Circular buffer; head/tail have $clog2(N)+1 bits. full = idx equal && wrap differ;
//    empty = pointers equal.
//  - bq_push_io.bqid = tail[idx] combinationally, valid whenever not full (decode samples it the
//    same cycle it asserts valid).
//  - Push accepted iff valid && !full && !squash_io.valid && !mispredict_now. Write {pc,id,bp,
//    resolved=0}, tail++. Push while full: dropped, bq_overflow_o <= 1. full uses current-cycle count
//    (a same-cycle pop does not free a slot for the push).
//  - Resolve: ignored if entry at bu_bqid_i is not valid (already flushed). Otherwise store taken/
//    target, resolved <= 1. mispredict_now = bu_taken_i != bp.taken ||
//    (bu_taken_i && bu_target_i != bp.pcnext).
//  - Mispredict: tail <= bu_bqid_i+1 (same wrap domain as the entry); younger entries invalidated.
//    Next cycle squash_io.valid=1 for exactly one cycle, id=entry.id,
//    pc = taken ? bu_target_i : entry.pc+4. A second mispredict in the squash cycle is legal only
//    for an older entry; it re-truncates and produces a new pulse the following cycle.
//  - Commit: pop iff cm_valid_i && head valid && resolved; else ignored. Clear valid, head++.
//    Pop of the mispredicted entry in the same cycle as its resolve is allowed (resolved bypass).
//  - Simultaneous push+pop+resolve: all applied. Mispredict truncation overrides the push.
//  - Wrap-around: pointers wrap mod 2N; bqid reuse is safe because the entry is freed only at commit.
//  - Reset mid-operation: everything returns to reset values immediately, with no squash pulse.
// STRUCTURE
//  - Package C: NB_BQ_ENTRY, bqid_t, bq_entry_t {valid,resolved,taken,pc,id,bp,target}.
//    bp_t, pc_t and id_t come from the existing C package.
//  - Sub-module bq_ptr (wrap-bit pointer with inc/load) instantiated for head and tail.
//    Misprediction compare stays inline.
// TESTING
//  1. Push 8 branches (pc 0x100..0x11C, id 1..8) -> bqid 0..7, full=1 after the 8th; a 9th push
//     sets overflow=1 and tail is unchanged.
//  2. bp.taken=1, pcnext=0x200; resolve taken target 0x200 -> no squash; commit pops, head=1.
//  3. Entries 0..4; resolve bqid 2, predicted not taken, actual taken 0x400 -> next cycle squash
//     valid, id of entry 2, pc 0x400; tail=3; a later resolve of bqid 4 is ignored.
//  4. bqid 1 (pc 0x104) predicted taken, actually not taken -> squash pc 0x108; a push in the
//     resolve cycle and in the squash cycle is dropped.
//  5. Fill/commit 20 times across wrap -> bqid sequence 0..7,0..; full/empty flags correct at
//     every step.
//  6. Assert rstn low while a squash is pending -> no squash pulse, queue empty, all outputs 0.

Source files
------------

// File: rtl/branch_queue_pkg.sv
// Shared types for the branch queue: pc/id/prediction types, queue sizing and entry layout.
package branch_queue_pkg;

    localparam int NB_BQ_ENTRY = 8;
    localparam int BQ_IDX_W    = $clog2(NB_BQ_ENTRY);
    localparam int BQ_PTR_W    = BQ_IDX_W + 1;

    typedef logic [31:0]         pc_t;
    typedef logic [7:0]          id_t;
    typedef logic [BQ_IDX_W-1:0] bqid_t;
    typedef logic [BQ_PTR_W-1:0] bqptr_t;

    typedef struct packed {
        logic taken;
        pc_t  pcnext;
    } bp_t;

    typedef struct packed {
        logic valid;
        logic resolved;
        logic taken;
        pc_t  pc;
        id_t  id;
        bp_t  bp;
        pc_t  target;
    } bq_entry_t;

    // Distance of a slot from the head; larger means younger.
    function automatic bqid_t bq_age(input bqid_t idx, input bqid_t head);
        return idx - head;
    endfunction

endpackage

// File: rtl/branch_queue_if.sv
// Push channel from decode and squash channel towards the front end.
interface bq_push_if;
    import branch_queue_pkg::*;

    logic  valid;
    pc_t   pc;
    id_t   id;
    bp_t   bp;
    bqid_t bqid;

    modport slave  (input valid, input pc, input id, input bp, output bqid);
    modport master (output valid, output pc, output id, output bp, input bqid);
endinterface

interface squash_if;
    import branch_queue_pkg::*;

    logic valid;
    id_t  id;
    pc_t  pc;

    modport master (output valid, output id, output pc);
    modport slave  (input valid, input id, input pc);
endinterface

// File: rtl/branch_queue_ptr.sv
// Circular-buffer pointer with an extra wrap bit; load has priority over increment.
module bq_ptr
    import branch_queue_pkg::*;
(
    input  logic   clk,
    input  logic   rstn,
    input  logic   inc_i,
    input  logic   load_i,
    input  bqptr_t load_val_i,
    output bqptr_t ptr_o
);

    bqptr_t ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = load_val_i;
        end else if (inc_i) begin
            ptr_d = ptr_q + bqptr_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/branch_queue.sv
// Branch queue: allocates a slot per pushed control-flow op, resolves it against the
// branch unit, truncates younger slots and emits a one-cycle squash on a mispredict.
module branch_queue
    import branch_queue_pkg::*;
(
    input  logic      clk,
    input  logic      rstn,
    bq_push_if.slave  bq_push_io,
    output logic      bq_full_o,
    output logic      bq_overflow_o,
    input  logic      bu_valid_i,
    input  bqid_t     bu_bqid_i,
    input  logic      bu_taken_i,
    input  pc_t       bu_target_i,
    input  logic      cm_valid_i,
    output logic      head_resolved_o,
    squash_if.master  squash_io
);

    bq_entry_t entries_q [NB_BQ_ENTRY];
    bq_entry_t entries_d [NB_BQ_ENTRY];
    logic      squash_valid_q, squash_valid_d;
    bqid_t     squash_idx_q, squash_idx_d;
    logic      overflow_q, overflow_d;

    bqptr_t    head_ptr, tail_ptr, misp_ptr;
    bqid_t     head_idx, tail_idx, misp_age;
    logic      full, resolve_ok, mispredict_now, pop, push_ok;
    bq_entry_t bu_entry, head_entry, sq_entry;

    assign head_idx   = head_ptr[BQ_IDX_W-1:0];
    assign tail_idx   = tail_ptr[BQ_IDX_W-1:0];
    assign full       = (head_idx == tail_idx) && (head_ptr[BQ_IDX_W] != tail_ptr[BQ_IDX_W]);
    assign bu_entry   = entries_q[bu_bqid_i];
    assign head_entry = entries_q[head_idx];
    assign sq_entry   = entries_q[squash_idx_q];

    assign resolve_ok     = bu_valid_i && bu_entry.valid;
    assign mispredict_now = resolve_ok &&
                            ((bu_taken_i != bu_entry.bp.taken) ||
                             (bu_taken_i && (bu_target_i != bu_entry.bp.pcnext)));

    // A head resolved this very cycle may retire immediately.
    assign pop     = cm_valid_i && head_entry.valid &&
                     (head_entry.resolved || (resolve_ok && (bu_bqid_i == head_idx)));
    assign push_ok = bq_push_io.valid && !full && !squash_valid_q && !mispredict_now;

    // Slots below the head index belong to the head's next lap.
    assign misp_ptr = {(bu_bqid_i >= head_idx) ? head_ptr[BQ_IDX_W] : ~head_ptr[BQ_IDX_W], bu_bqid_i};
    assign misp_age = bq_age(bu_bqid_i, head_idx);

    bq_ptr u_head_ptr (
        .clk        (clk),
        .rstn       (rstn),
        .inc_i      (pop),
        .load_i     (1'b0),
        .load_val_i ('0),
        .ptr_o      (head_ptr)
    );

    bq_ptr u_tail_ptr (
        .clk        (clk),
        .rstn       (rstn),
        .inc_i      (push_ok),
        .load_i     (mispredict_now),
        .load_val_i (misp_ptr + bqptr_t'(1)),
        .ptr_o      (tail_ptr)
    );

    always_comb begin
        entries_d = entries_q;
        if (resolve_ok) begin
            entries_d[bu_bqid_i].resolved = 1'b1;
            entries_d[bu_bqid_i].taken    = bu_taken_i;
            entries_d[bu_bqid_i].target   = bu_target_i;
        end
        if (mispredict_now) begin
            for (int i = 0; i < NB_BQ_ENTRY; i++) begin
                if (bq_age(bqid_t'(i), head_idx) > misp_age) begin
                    entries_d[i].valid = 1'b0;
                end
            end
        end
        if (pop) begin
            entries_d[head_idx].valid = 1'b0;
        end
        if (push_ok) begin
            entries_d[tail_idx] = '{valid: 1'b1, resolved: 1'b0, taken: 1'b0,
                                    pc: bq_push_io.pc, id: bq_push_io.id,
                                    bp: bq_push_io.bp, target: '0};
        end
    end

    always_comb begin
        squash_valid_d = mispredict_now;
        squash_idx_d   = mispredict_now ? bu_bqid_i : squash_idx_q;
        overflow_d     = overflow_q || (bq_push_io.valid && full);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            entries_q      <= '{default: '0};
            squash_valid_q <= 1'b0;
            squash_idx_q   <= '0;
            overflow_q     <= 1'b0;
        end else begin
            entries_q      <= entries_d;
            squash_valid_q <= squash_valid_d;
            squash_idx_q   <= squash_idx_d;
            overflow_q     <= overflow_d;
        end
    end

    // The mispredicted slot keeps its data during the squash cycle since pushes are blocked then.
    assign squash_io.valid = squash_valid_q;
    assign squash_io.id    = squash_valid_q ? sq_entry.id : '0;
    assign squash_io.pc    = squash_valid_q ? (sq_entry.taken ? sq_entry.target : sq_entry.pc + 32'd4) : '0;

    assign bq_push_io.bqid = tail_idx;
    assign bq_full_o       = full;
    assign bq_overflow_o   = overflow_q;
    assign head_resolved_o = head_entry.valid && head_entry.resolved;

endmodule
